// File: rtl/i2s_ctrl.sv
// i2s_ctrl: frame-aligned start/stop sequencing plus TX/RX stereo sample FIFOs for the i2s core.
// The RX capture path is built only when the I2S_CTRL_RX_EN macro is defined.
module i2s_ctrl #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_we,
    input  logic        cfg_master,
    input  logic [19:0] cfg_bdiv,
    input  logic [7:0]  cfg_lrdiv,
    output logic        cfg_rej,
    input  logic        start,
    input  logic        stop,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [31:0] tx_data_l,
    input  logic [31:0] tx_data_r,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [31:0] rx_data_l,
    output logic [31:0] rx_data_r,
    input  logic [2:0]  core_cst,
    output logic        core_master_enable,
    output logic [19:0] core_bdiv,
    output logic [7:0]  core_lrdiv,
    output logic [31:0] core_din_l,
    output logic [31:0] core_din_r,
    input  logic [31:0] core_dout_l,
    input  logic [31:0] core_dout_r,
    output logic        busy,
    output logic        tx_underrun,
    output logic        rx_overrun,
    input  logic        status_clr,
    output logic [15:0] frame_cnt
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SYNC  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [1:0]  state;
    logic [1:0]  state_nx;
    logic [2:0]  cst_prev;
    logic        fe;
    logic        active;
    logic        master;

    logic [63:0]           tx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] tx_wr;
    logic [DEPTH_LOG2-1:0] tx_rd;
    logic [DEPTH_LOG2:0]   tx_cnt;
    logic                  tx_empty;
    logic                  tx_push;
    logic                  tx_pop_req;
    logic                  tx_pop;
    logic                  underrun_set;

    // A frame ends when the core moves from the right-channel state back to idle_r.
    assign fe       = (cst_prev == 3'd1) && (core_cst == 3'd0);
    assign active   = (state == ST_RUN) || (state == ST_DRAIN);
    assign busy     = (state != ST_IDLE);
    assign core_master_enable = master && busy;

    assign tx_empty = (tx_cnt == {(DEPTH_LOG2+1){1'b0}});
    assign tx_ready = (tx_cnt != CNT_FULL);
    assign tx_push  = tx_valid && tx_ready;
    // The SYNC->RUN frame primes the core; a stop in SYNC takes priority and skips it.
    assign tx_pop_req   = fe && (active || ((state == ST_SYNC) && !stop));
    assign tx_pop       = tx_pop_req && !tx_empty;
    assign underrun_set = tx_pop_req && tx_empty && active;

    // Next-state sequencing; stop dominates start in IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (start && !stop) state_nx = ST_SYNC;
                else                state_nx = ST_IDLE;
            end
            ST_SYNC: begin
                if (stop)    state_nx = ST_IDLE;
                else if (fe) state_nx = ST_RUN;
                else         state_nx = ST_SYNC;
            end
            ST_RUN: begin
                if (stop) state_nx = ST_DRAIN;
                else      state_nx = ST_RUN;
            end
            ST_DRAIN: begin
                if (fe && tx_empty) state_nx = ST_IDLE;
                else                state_nx = ST_DRAIN;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State, frame-edge history, configuration and frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cst_prev  <= 3'd0;
            master    <= 1'b0;
            core_bdiv <= 20'd0;
            core_lrdiv <= 8'd0;
            cfg_rej   <= 1'b0;
            frame_cnt <= 16'd0;
        end else begin
            state    <= state_nx;
            cst_prev <= core_cst;
            cfg_rej  <= cfg_we && busy;
            if (cfg_we && !busy) begin
                master     <= cfg_master;
                core_bdiv  <= cfg_bdiv;
                core_lrdiv <= cfg_lrdiv;
            end
            if ((state == ST_IDLE) && (state_nx == ST_SYNC)) frame_cnt <= 16'd0;
            else if (fe && active)                           frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // TX FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr  <= {DEPTH_LOG2{1'b0}};
            tx_rd  <= {DEPTH_LOG2{1'b0}};
            tx_cnt <= {(DEPTH_LOG2+1){1'b0}};
        end else begin
            if (tx_push) tx_wr <= tx_wr + PTR_ONE;
            if (tx_pop)  tx_rd <= tx_rd + PTR_ONE;
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + CNT_ONE;
                2'b01:   tx_cnt <= tx_cnt - CNT_ONE;
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    // TX FIFO storage.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr] <= {tx_data_l, tx_data_r};
    end

    // Core transmit data and the sticky underrun flag; an empty FIFO feeds silence.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_din_l  <= 32'd0;
            core_din_r  <= 32'd0;
            tx_underrun <= 1'b0;
        end else begin
            if (tx_pop) begin
                core_din_l <= tx_mem[tx_rd][63:32];
                core_din_r <= tx_mem[tx_rd][31:0];
            end else if (tx_pop_req) begin
                core_din_l <= 32'd0;
                core_din_r <= 32'd0;
            end
            if (underrun_set)    tx_underrun <= 1'b1;
            else if (status_clr) tx_underrun <= 1'b0;
        end
    end

`ifdef I2S_CTRL_RX_EN
    logic [63:0]           rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rx_wr;
    logic [DEPTH_LOG2-1:0] rx_rd;
    logic [DEPTH_LOG2:0]   rx_cnt;
    logic                  rx_cap;
    logic                  rx_full;
    logic                  rx_store;
    logic                  rx_pop;

    // Fullness is judged on pre-pop occupancy, so a same-cycle host pop cannot rescue a capture.
    assign rx_cap    = fe && active;
    assign rx_full   = (rx_cnt == CNT_FULL);
    assign rx_store  = rx_cap && !rx_full;
    assign rx_valid  = (rx_cnt != {(DEPTH_LOG2+1){1'b0}});
    assign rx_pop    = rx_valid && rx_ready;
    assign rx_data_l = rx_mem[rx_rd][63:32];
    assign rx_data_r = rx_mem[rx_rd][31:0];

    // RX FIFO pointers, occupancy and the sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wr      <= {DEPTH_LOG2{1'b0}};
            rx_rd      <= {DEPTH_LOG2{1'b0}};
            rx_cnt     <= {(DEPTH_LOG2+1){1'b0}};
            rx_overrun <= 1'b0;
        end else begin
            if (rx_store) rx_wr <= rx_wr + PTR_ONE;
            if (rx_pop)   rx_rd <= rx_rd + PTR_ONE;
            case ({rx_store, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + CNT_ONE;
                2'b01:   rx_cnt <= rx_cnt - CNT_ONE;
                default: rx_cnt <= rx_cnt;
            endcase
            if (rx_cap && rx_full) rx_overrun <= 1'b1;
            else if (status_clr)   rx_overrun <= 1'b0;
        end
    end

    // RX FIFO storage.
    always_ff @(posedge clk) begin
        if (rx_store) rx_mem[rx_wr] <= {core_dout_l, core_dout_r};
    end
`else
    logic unused_rx;
    assign unused_rx  = ^{core_dout_l, core_dout_r, rx_ready};
    assign rx_valid   = 1'b0;
    assign rx_data_l  = 32'd0;
    assign rx_data_r  = 32'd0;
    assign rx_overrun = 1'b0;
`endif

endmodule
